// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/write-back sequencer for the regfile + ALU core.
// Ports: clk, rst_n, start (in); imem_req/addr/rdata/valid (fetch handshake);
//   alu_sel, rf_addr1/2/w, rf_we (datapath control); busy, halted, err, pc,
//   retired (status). Define CPU_SEQ_STEP_EN to add step_mode/step inputs and
//   a PAUSE state after each write-back.
module cpu_sequencer #(
  parameter int PC_W    = 8,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef CPU_SEQ_STEP_EN
  input  logic             step_mode,
  input  logic             step,
`endif
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic [31:0]      imem_rdata,
  input  logic             imem_valid,
  output logic [1:0]       alu_sel,
  output logic [4:0]       rf_addr1,
  output logic [4:0]       rf_addr2,
  output logic [4:0]       rf_addrw,
  output logic             rf_we,
  output logic             busy,
  output logic             halted,
  output logic             err,
  output logic [PC_W-1:0]  pc,
  output logic [CNT_W-1:0] retired
);

  localparam int WC_W = $clog2(TIMEOUT + 1);
  localparam logic [WC_W-1:0] TMO_LAST = WC_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_EXEC,
    S_WB,
`ifdef CPU_SEQ_STEP_EN
    S_PAUSE,
`endif
    S_HALT
  } state_e;

  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [31:0]      ir_q, ir_d;
  logic [CNT_W-1:0] ret_q, ret_d, ret_inc;
  logic             err_q, err_d;
  logic [WC_W-1:0]  cnt_q, cnt_d;
  logic             req_q, busy_q, halt_q, we_q;

  // Retired counter sticks at all-ones instead of wrapping.
  assign ret_inc = (&ret_q) ? ret_q : ret_q + 1'b1;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    ret_d   = ret_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          pc_d    = '0;
          ret_d   = '0;
          err_d   = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A response on the last allowed cycle still wins over timeout.
        if (imem_valid) begin
          ir_d    = imem_rdata;
          state_d = S_EXEC;
        end else if (cnt_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_HALT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_EXEC: begin
        if (ir_q[2:0] == 3'b111) begin
          ret_d   = ret_inc;
          state_d = S_HALT;
        end else begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        pc_d    = pc_q + 1'b1;
        ret_d   = ret_inc;
        state_d = S_FETCH;
`ifdef CPU_SEQ_STEP_EN
        if (step_mode) state_d = S_PAUSE;
`endif
      end
`ifdef CPU_SEQ_STEP_EN
      S_PAUSE: begin
        if (step || !step_mode) state_d = S_FETCH;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Status/control flags are registered from the next state so they
  // line up with state_q without a decode after the flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      ret_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      halt_q  <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ret_q   <= ret_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      req_q   <= (state_d == S_FETCH);
      busy_q  <= (state_d == S_FETCH) || (state_d == S_WAIT)
`ifdef CPU_SEQ_STEP_EN
              || (state_d == S_PAUSE)
`endif
              || (state_d == S_EXEC) || (state_d == S_WB);
      halt_q  <= (state_d == S_HALT);
      we_q    <= (state_d == S_WB) && (ir_d[2:0] < 3'd4);
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign alu_sel   = ir_q[1:0];
  assign rf_addr1  = ir_q[12:8];
  assign rf_addr2  = ir_q[17:13];
  assign rf_addrw  = ir_q[22:18];
  assign rf_we     = we_q;
  assign busy      = busy_q;
  assign halted    = halt_q;
  assign err       = err_q;
  assign pc        = pc_q;
  assign retired   = ret_q;

  logic unused_ir;
  assign unused_ir = ^{ir_q[31:23], ir_q[7:3]};

endmodule

// File: tb/tb_cpu_sequencer.sv
// Randomized lockstep bench for cpu_sequencer with an imem responder
// and an instruction-level model of pc / retired / err / halt.
module tb_cpu_sequencer;
  localparam int PC_W = 8;
  localparam int CNT_W = 16;
  localparam int TMO = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic imem_valid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic imem_req, rf_we, busy, halted, err;
  logic [PC_W-1:0] imem_addr, pc;
  logic [1:0] alu_sel;
  logic [4:0] rf_addr1, rf_addr2, rf_addrw;
  logic [CNT_W-1:0] retired;
`ifdef CPU_SEQ_STEP_EN
  logic step_mode = 1'b0;
  logic step = 1'b0;
`endif

  cpu_sequencer #(.PC_W(PC_W), .CNT_W(CNT_W), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
`ifdef CPU_SEQ_STEP_EN
    .step_mode(step_mode), .step(step),
`endif
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .alu_sel(alu_sel), .rf_addr1(rf_addr1), .rf_addr2(rf_addr2),
    .rf_addrw(rf_addrw), .rf_we(rf_we), .busy(busy),
    .halted(halted), .err(err), .pc(pc), .retired(retired)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;
  int m_pc = 0;
  int m_ret = 0;
  int m_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v >= (1 << CNT_W) - 1) ? v : v + 1;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_req"}, 32'(imem_req), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_halt"}, 32'(halted), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_pc"}, 32'(pc), 0);
    chk({tag, "_addr"}, 32'(imem_addr), 0);
    chk({tag, "_ret"}, 32'(retired), 0);
    chk({tag, "_we"}, 32'(rf_we), 0);
    chk({tag, "_rf"}, 32'({alu_sel, rf_addr1, rf_addr2, rf_addrw}), 0);
  endtask

  // Called at a negedge with the DUT idle or halted; returns at FETCH.
  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_pc = 0;
    m_ret = 0;
    m_err = 0;
  endtask

  task automatic chk_fields(input string tag, input logic [31:0] w);
    chk({tag, "_a1"}, 32'(rf_addr1), 32'(w[12:8]));
    chk({tag, "_a2"}, 32'(rf_addr2), 32'(w[17:13]));
    chk({tag, "_aw"}, 32'(rf_addrw), 32'(w[22:18]));
    chk({tag, "_alu"}, 32'(alu_sel), 32'(w[1:0]));
  endtask

  // Entered at the negedge where FETCH is expected. dly = WAIT cycle
  // on which valid is driven; dly > TMO means no response at all.
  task automatic run_instr(input logic [31:0] w, input int dly,
                           input bit spur);
    chk("f_req", 32'(imem_req), 1);
    chk("f_addr", 32'(imem_addr), 32'(m_pc));
    chk("f_busy", 32'(busy), 1);
    chk("f_ret", 32'(retired), 32'(m_ret));
    chk("f_err", 32'(err), 32'(m_err));
    start = 1'($urandom_range(0, 1));
    for (int k = 1; k <= TMO; k++) begin
      @(negedge clk);
      chk("w_req", 32'(imem_req), 0);
      start = 1'($urandom_range(0, 1));
      if (k == dly) begin
        imem_valid = 1'b1;
        imem_rdata = w;
        break;
      end
      imem_valid = 1'b0;
      imem_rdata = $urandom;
    end
    @(negedge clk);
    imem_valid = 1'b0;
    if (dly > TMO) begin
      m_err = 1;
      start = 1'b0;
      chk("to_halt", 32'(halted), 1);
      chk("to_err", 32'(err), 1);
      chk("to_busy", 32'(busy), 0);
      chk("to_pc", 32'(pc), 32'(m_pc));
      chk("to_req", 32'(imem_req), 0);
      return;
    end
    chk("x_we", 32'(rf_we), 0);
    chk("x_busy", 32'(busy), 1);
    chk_fields("x", w);
    start = 1'($urandom_range(0, 1));
    if (spur) begin
      imem_valid = 1'b1;
      imem_rdata = ~w;
    end
    @(negedge clk);
    imem_valid = 1'b0;
    if (w[2:0] == 3'b111) begin
      m_ret = sat_inc(m_ret);
      start = 1'b0;
      chk("h_halt", 32'(halted), 1);
      chk("h_busy", 32'(busy), 0);
      chk("h_pc", 32'(pc), 32'(m_pc));
      chk("h_ret", 32'(retired), 32'(m_ret));
      chk("h_err", 32'(err), 0);
      return;
    end
    chk("b_we", 32'(rf_we), 32'(w[2:0] < 3'd4));
    chk("b_busy", 32'(busy), 1);
    chk("b_pc", 32'(pc), 32'(m_pc));
    chk_fields("b", w);
    m_pc = (m_pc + 1) % (1 << PC_W);
    m_ret = sat_inc(m_ret);
    start = 1'($urandom_range(0, 1));
    @(negedge clk);
`ifdef CPU_SEQ_STEP_EN
    if (step_mode) begin
      for (int p = 0; p < 3; p++) begin
        chk("p_busy", 32'(busy), 1);
        chk("p_req", 32'(imem_req), 0);
        chk("p_we", 32'(rf_we), 0);
        chk("p_pc", 32'(pc), 32'(m_pc));
        chk("p_ret", 32'(retired), 32'(m_ret));
        if (p == 2) step = 1'b1;
        @(negedge clk);
      end
      step = 1'b0;
    end
`endif
    chk("n_pc", 32'(pc), 32'(m_pc));
    chk("n_ret", 32'(retired), 32'(m_ret));
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    w[2:0] = 3'($urandom_range(0, 6));
    return w;
  endfunction

  initial begin
    repeat (2) @(negedge clk);
    chk_zero("rst");
    rst_n = 1'b1;
    imem_valid = 1'b1;
    imem_rdata = 32'hFFFF_FFF0;
    @(negedge clk);
    imem_valid = 1'b0;
    chk_zero("idle");

    // Single ALU instruction with immediate response.
    do_start();
    run_instr(32'h0004_2101, 1, 1'b0);

    // NOP then HALT; no fetch afterwards.
    chk("t2_idle", 32'(busy), 1);
    start = 1'b0;
    @(negedge clk);
    repeat (40) @(negedge clk);
    do_start();
    run_instr(32'h0000_0005, 1, 1'b0);
    run_instr(32'h0000_0007, 1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      imem_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("t2_req", 32'(imem_req), 0);
      chk("t2_halt", 32'(halted), 1);
      chk("t2_pc", 32'(pc), 1);
      chk("t2_ret", 32'(retired), 2);
    end
    imem_valid = 1'b0;

    // Fetch timeout, sticky err, then restart clears it.
    do_start();
    run_instr(32'h0000_0001, 1, 1'b0);
    run_instr(rand_word(), TMO + 1, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("t3_err", 32'(err), 1);
      chk("t3_pc", 32'(pc), 1);
    end
    do_start();
    chk("t3_clr", 32'(err), 0);
    chk("t3_pc0", 32'(pc), 0);

    // Valid on the last WAIT cycle, plus a stray valid during EXEC.
    run_instr(32'h0123_4562, TMO, 1'b1);
    run_instr(rand_word(), TMO, 1'b0);

    // Long random run walks pc through 255 -> 0.
    for (int i = 0; i < 270; i++)
      run_instr(rand_word(), $urandom_range(1, 4), 1'($urandom_range(0, 1)));

    // Reset mid-WAIT, then a late valid is ignored.
    chk("t5_req", 32'(imem_req), 1);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk_zero("t5_rst");
    rst_n = 1'b1;
    imem_valid = 1'b1;
    imem_rdata = 32'h007F_FF03;
    @(negedge clk);
    imem_valid = 1'b0;
    chk_zero("t5_late");
    do_start();
    run_instr(rand_word(), 2, 1'b0);

`ifdef CPU_SEQ_STEP_EN
    step_mode = 1'b1;
    for (int i = 0; i < 3; i++) run_instr(rand_word(), 1, 1'b0);
    step_mode = 1'b0;
    run_instr(rand_word(), 1, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
